mem_arbiter: RTL and testbench

Two-requester memory-port arbiter sharing the single external memory bus (16-bit address, 8-bit data) between the CPU core and the front-panel program loader. It serialises accesses, inserts a parameterised number of wait states for slow memory, and returns read data with a one-cycle completion pulse. It sits between the CPU's `addr`/`data_out`/`read`/`write` lines, the loader, and the memory device.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for the shared 16-bit address / 8-bit data
// memory bus. Requester 0 is the CPU and requester 1 is the front-panel loader.
// Each access is granted, held for WAIT_CYCLES+1 strobe cycles, and then ends
// with a one-cycle done pulse. When both requesters ask, they alternate.
//
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   hold                          blocks new grants (an in-flight access still finishes)
//   req0/we0/addr0/wdata0         CPU request; we/addr/wdata are sampled at grant
//   req1/we1/addr1/wdata1         loader request, with the same rules
//   gnt0, gnt1                    owner of the bus, in ACCESS and DONE
//   done0, done1                  one-cycle completion pulse
//   rdata                         last read data; held until the next read completes
//   mem_addr, mem_wdata           memory address and write data; hold their values between accesses
//   mem_rd, mem_wr                memory strobes, high only in ACCESS
//   mem_rdata                     data returned by memory
//   busy                          high whenever the FSM is not IDLE
//
// state  | meaning
// IDLE   | no access; a grant is evaluated here only
// ACCESS | strobe active, wait counter running down
// DONE   | completion pulse to the owner, strobes low
module mem_arbiter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        req0,
   input  logic        we0,
   input  logic [15:0] addr0,
   input  logic [7:0]  wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [15:0] addr1,
   input  logic [7:0]  wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [7:0]  rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [7:0]  mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        last;
   logic        owner;
   logic        lat_we;
   logic [3:0]  cnt;
   logic        grant_ok;
   logic        winner;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_ok  = 1'b0;
      winner    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!hold && (req0 || req1)) begin
               grant_ok  = 1'b1;
               // Under contention, the requester that did not win last time wins now.
               winner    = (req0 && req1) ? ~last : req1;
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt == 4'd0) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // mem_addr and mem_wdata are loaded at grant. This makes them the latched
   // request registers, and they naturally hold their value between accesses.
   always_ff @(posedge clk) begin
      if (rst) begin
         last      <= 1'b1;
         owner     <= 1'b0;
         lat_we    <= 1'b0;
         cnt       <= 4'd0;
         mem_addr  <= 16'h0000;
         mem_wdata <= 8'h00;
         rdata     <= 8'h00;
      end else begin
         if (grant_ok) begin
            last      <= winner;
            owner     <= winner;
            lat_we    <= winner ? we1 : we0;
            mem_addr  <= winner ? addr1 : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
            cnt       <= 4'(WAIT_CYCLES);
         end else if (state == ST_ACCESS) begin
            if (cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end else if (!lat_we) begin
               rdata <= mem_rdata;
            end
         end
      end
   end

   always_comb begin
      busy   = (state != ST_IDLE);
      gnt0   = busy && !owner;
      gnt1   = busy && owner;
      done0  = (state == ST_DONE) && !owner;
      done1  = (state == ST_DONE) && owner;
      mem_rd = (state == ST_ACCESS) && !lat_we;
      mem_wr = (state == ST_ACCESS) && lat_we;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. It builds three instances with WAIT_CYCLES of 0, 1 and 3.
// Requests reach only the instance chosen by sel. Each instance has its own
// memory device model. The expected results come from a transaction-level
// reference: round-robin on a last-winner bit, a reference memory array, and
// latency / strobe counts taken from the access timing rules.
module tb_mem_arbiter;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hold = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [15:0] addr0 = 16'h0, addr1 = 16'h0;
   logic [7:0]  wdata0 = 8'h0, wdata1 = 8'h0;
   int          sel = 1;

   logic        gnt0_v[NI], gnt1_v[NI], done0_v[NI], done1_v[NI];
   logic        mem_rd_v[NI], mem_wr_v[NI], busy_v[NI];
   logic [7:0]  rdata_v[NI], mem_wdata_v[NI], mem_rdata_v[NI];
   logic [15:0] mem_addr_v[NI];

   logic [7:0]  dev_mem[NI][65536];
   logic [7:0]  ref_mem[NI][65536];
   logic [7:0]  exp_rdata[NI];
   logic        ref_last[NI];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic int wt(input int g);
      return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
   endfunction

   function automatic logic [7:0] seed_val(input logic [15:0] a);
      return (a == 16'h0123) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_arbiter #(.WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))) u_dut (
         .clk       (clk),
         .rst       (rst),
         .hold      (hold),
         .req0      (req0 && (sel == g)),
         .we0       (we0),
         .addr0     (addr0),
         .wdata0    (wdata0),
         .req1      (req1 && (sel == g)),
         .we1       (we1),
         .addr1     (addr1),
         .wdata1    (wdata1),
         .gnt0      (gnt0_v[g]),
         .gnt1      (gnt1_v[g]),
         .done0     (done0_v[g]),
         .done1     (done1_v[g]),
         .rdata     (rdata_v[g]),
         .mem_addr  (mem_addr_v[g]),
         .mem_wdata (mem_wdata_v[g]),
         .mem_rd    (mem_rd_v[g]),
         .mem_wr    (mem_wr_v[g]),
         .mem_rdata (mem_rdata_v[g]),
         .busy      (busy_v[g])
      );
      assign mem_rdata_v[g] = dev_mem[g][mem_addr_v[g]];
   end

   // Memory device model: asynchronous read, write on the clock edge while mem_wr is high.
   initial begin
      for (int g = 0; g < NI; g++)
         for (int i = 0; i < 65536; i++)
            dev_mem[g][i] = seed_val(16'(i));
      forever begin
         @(posedge clk);
         for (int g = 0; g < NI; g++)
            if (mem_wr_v[g] === 1'b1) dev_mem[g][mem_addr_v[g]] <= mem_wdata_v[g];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (inst %0d, t=%0t)", tag, obs, exp, sel, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int g = 0; g < NI; g++) begin
            chk("mutex_gnt", 32'(gnt0_v[g] & gnt1_v[g]), 32'd0);
            chk("mutex_strobe", 32'(mem_rd_v[g] & mem_wr_v[g]), 32'd0);
            chk("done_implies_gnt", 32'((done0_v[g] & ~gnt0_v[g]) | (done1_v[g] & ~gnt1_v[g])), 32'd0);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_model();
      for (int g = 0; g < NI; g++) begin
         exp_rdata[g] = 8'h00;
         ref_last[g]  = 1'b1;
      end
   endtask

   // One single-requester access. The DUT must be IDLE when this is called.
   task automatic txn(input logic who, input logic w, input logic [15:0] a, input logic [7:0] d);
      int W;
      int cyc;
      int strobes;
      int lat;
      W = wt(sel); cyc = 0; strobes = 0; lat = -1;
      if (w) ref_mem[sel][a] = d;
      else   exp_rdata[sel] = ref_mem[sel][a];
      if (who == 1'b0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
      else             begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
      while (lat < 0 && cyc < 40) begin
         tick();
         cyc++;
         if (cyc == 1) begin
            chk("gnt_owner", 32'(who ? gnt1_v[sel] : gnt0_v[sel]), 32'd1);
            chk("gnt_other", 32'(who ? gnt0_v[sel] : gnt1_v[sel]), 32'd0);
         end
         if ((w ? mem_wr_v[sel] : mem_rd_v[sel]) === 1'b1) begin
            strobes++;
            chk("mem_addr", 32'(mem_addr_v[sel]), 32'(a));
            if (w) chk("mem_wdata", 32'(mem_wdata_v[sel]), 32'(d));
         end
         if ((who ? done1_v[sel] : done0_v[sel]) === 1'b1) begin
            lat = cyc;
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      chk("latency", 32'(lat), 32'(W + 2));
      chk("strobe_cycles", 32'(strobes), 32'(W + 1));
      chk("rdata", 32'(rdata_v[sel]), 32'(exp_rdata[sel]));
      ref_last[sel] = who;
      tick();
      chk("done_one_cycle", 32'(done0_v[sel] | done1_v[sel]), 32'd0);
      chk("idle_after", 32'(busy_v[sel]), 32'd0);
   endtask

   // Both requesters hold req high for n completed transactions.
   task automatic contend(input int n, input logic w0, input logic w1,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [7:0] d0, input logic [7:0] d1);
      int W;
      int cyc;
      int dones;
      int last_gcyc;
      logic prev_g;
      logic g_now;
      logic own;
      W = wt(sel); cyc = 0; dones = 0; last_gcyc = -1; prev_g = 1'b0;
      req0 = 1'b1; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = 1'b1; we1 = w1; addr1 = a1; wdata1 = d1;
      while (dones < n && cyc < n * (W + 3) + 20) begin
         tick();
         cyc++;
         g_now = gnt0_v[sel] | gnt1_v[sel];
         if (g_now === 1'b1 && prev_g !== 1'b1) begin
            own = ~ref_last[sel];
            chk("rr_order", 32'(gnt1_v[sel]), 32'(own));
            if (last_gcyc >= 0) chk("rr_period", 32'(cyc - last_gcyc), 32'(W + 3));
            last_gcyc = cyc;
            ref_last[sel] = own;
            if (own) begin
               if (w1) ref_mem[sel][a1] = d1; else exp_rdata[sel] = ref_mem[sel][a1];
            end else begin
               if (w0) ref_mem[sel][a0] = d0; else exp_rdata[sel] = ref_mem[sel][a0];
            end
         end
         prev_g = g_now;
         if ((done0_v[sel] | done1_v[sel]) === 1'b1) begin
            dones++;
            chk("rr_rdata", 32'(rdata_v[sel]), 32'(exp_rdata[sel]));
            if (dones == n) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
      end
      chk("rr_done_count", 32'(dones), 32'(n));
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
   endtask

   task automatic chk_all_reset();
      for (int g = 0; g < NI; g++) begin
         chk("rst_gnt", 32'({gnt0_v[g], gnt1_v[g]}), 32'd0);
         chk("rst_done", 32'({done0_v[g], done1_v[g]}), 32'd0);
         chk("rst_strobe", 32'({mem_rd_v[g], mem_wr_v[g]}), 32'd0);
         chk("rst_busy", 32'(busy_v[g]), 32'd0);
         chk("rst_rdata", 32'(rdata_v[g]), 32'd0);
         chk("rst_mem_addr", 32'(mem_addr_v[g]), 32'd0);
         chk("rst_mem_wdata", 32'(mem_wdata_v[g]), 32'd0);
      end
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      for (int g = 0; g < NI; g++)
         for (int i = 0; i < 65536; i++)
            ref_mem[g][i] = seed_val(16'(i));
      reset_model();

      // Reset with both requests high, then run contention directly out of reset.
      sel = 1;
      rst = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      addr0 = 16'h0200; addr1 = 16'h0300;
      tick();
      tick();
      chk_all_reset();
      rst = 1'b0;
      contend(4, 1'b0, 1'b0, 16'h0200, 16'h0300, 8'h00, 8'h00);

      // Single CPU read on the WAIT_CYCLES=1 instance.
      sel = 1;
      txn(1'b0, 1'b0, 16'h0123, 8'h00);
      chk("cpu_read_A5", 32'(rdata_v[1]), 32'h0000_00A5);

      // Loader write on the WAIT_CYCLES=0 instance, after a read so that rdata is non-zero.
      sel = 0;
      txn(1'b0, 1'b0, 16'h0123, 8'h00);
      txn(1'b1, 1'b1, 16'h8000, 8'h3C);
      chk("write_keeps_rdata", 32'(rdata_v[0]), 32'h0000_00A5);
      txn(1'b0, 1'b0, 16'h8000, 8'h00);
      chk("readback_3C", 32'(rdata_v[0]), 32'h0000_003C);

      // With hold high, a loader request gets no grant. It is granted the cycle after hold drops.
      sel = 1;
      hold = 1'b1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0042;
      exp_rdata[1] = ref_mem[1][16'h0042];
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_no_gnt", 32'({gnt0_v[1], gnt1_v[1], busy_v[1]}), 32'd0);
      end
      hold = 1'b0;
      tick();
      chk("hold_release_gnt", 32'(gnt1_v[1]), 32'd1);
      tick();
      req1 = 1'b0;
      begin
         int k;
         k = 0;
         while (done1_v[1] !== 1'b1 && k < 10) begin
            tick();
            k++;
         end
         chk("withdraw_done1", 32'(done1_v[1]), 32'd1);
         chk("withdraw_rdata", 32'(rdata_v[1]), 32'(exp_rdata[1]));
      end
      ref_last[1] = 1'b1;
      tick();

      // Reset asserted in the second ACCESS cycle of the WAIT_CYCLES=3 instance.
      sel = 2;
      txn(1'b1, 1'b0, 16'h0123, 8'h00);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0555;
      tick();
      chk("mid_gnt0", 32'(gnt0_v[2]), 32'd1);
      tick();
      chk("mid_rd_active", 32'(mem_rd_v[2]), 32'd1);
      rst = 1'b1;
      req0 = 1'b0;
      tick();
      chk("mid_rst_strobes", 32'({mem_rd_v[2], mem_wr_v[2]}), 32'd0);
      chk("mid_rst_idle", 32'({busy_v[2], gnt0_v[2], done0_v[2]}), 32'd0);
      rst = 1'b0;
      reset_model();
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mid_rst_no_done", 32'(done0_v[2] | done1_v[2]), 32'd0);
      end
      contend(2, 1'b0, 1'b1, 16'h0777, 16'h0778, 8'h00, 8'h99);

      // Random single and contended accesses over a small address window, so that reads hit earlier writes.
      for (int it = 0; it < 30; it++) begin
         sel = int'($urandom_range(0, 2));
         ra = {12'h010, 4'($urandom)};
         rb = {12'h010, 4'($urandom)};
         if ($urandom_range(0, 3) == 0)
            contend(int'($urandom_range(2, 4)), 1'($urandom), 1'($urandom), ra, rb,
                    8'($urandom), 8'($urandom));
         else
            txn(1'($urandom), 1'($urandom), ra, 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
